// File: rtl/timer_pkg.sv
// Shared types and helpers for the turn timer.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} timer_state_t;

    // Value count_out takes after reset, clear, start and every expiry.
    function automatic int cnt_init(input int count_down, input int timeout_s);
        return (count_down != 0) ? timeout_s : 0;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk_in down to a one-cycle tick every CLK_HZ enabled cycles.
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/turn_timer.sv
// Second-resolution game timer: start/pause/clear/auto-reload, up or down count.
// Optional BCD outputs for the overlay are enabled with TURN_TIMER_BCD_EN.
module turn_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_S  = 10,
    parameter int COUNT_DOWN = 0,
    parameter int CNT_W      = $clog2(TIMEOUT_S + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             pause_in,
    input  logic             clear_in,
    input  logic             auto_reload_in,
    output logic             done,
    output logic             expired_out,
    output logic             running_out,
    output logic [CNT_W-1:0] count_out
`ifdef TURN_TIMER_BCD_EN
    ,
    output logic [3:0]       bcd_tens_out,
    output logic [3:0]       bcd_ones_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(COUNT_DOWN, TIMEOUT_S));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((COUNT_DOWN != 0) ? 1 : TIMEOUT_S - 1);

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             pre_clr, pre_en, tick;

    // PAUSE with pause_in low counts like RUN, so each paused cycle costs exactly one cycle.
    assign pre_clr = clear_in || start_in;
    assign pre_en  = ((state_q == RUN) || (state_q == PAUSE)) && !pause_in;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (pre_clr),
        .en     (pre_en),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (clear_in) begin
            state_d = IDLE;
            count_d = CNT_INIT;
        end else if (start_in) begin
            state_d = RUN;
            count_d = CNT_INIT;
        end else begin
            case (state_q)
                RUN, PAUSE: begin
                    if (pause_in) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = RUN;
                        if (tick) begin
                            if (count_q == CNT_LAST) begin
                                count_d = CNT_INIT;
                                done_d  = 1'b1;
                                if (!auto_reload_in) state_d = EXPIRED;
                            end else if (COUNT_DOWN != 0) begin
                                count_d = count_q - 1'b1;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            count_q   <= CNT_INIT;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            done_q    <= done_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign done        = done_q;
    assign expired_out = expired_q;
    assign running_out = running_q;
    assign count_out   = count_q;

`ifdef TURN_TIMER_BCD_EN
    if (TIMEOUT_S > 99) begin : g_bcd_range
        $error("turn_timer: BCD outputs need TIMEOUT_S <= 99");
    end

    localparam logic [3:0] BCD_TENS_INIT = 4'(int'(CNT_INIT) / 10);
    localparam logic [3:0] BCD_ONES_INIT = 4'(int'(CNT_INIT) % 10);

    logic [3:0] bcd_tens_q, bcd_tens_d;
    logic [3:0] bcd_ones_q, bcd_ones_d;

    // Derived from count_d so the digits change on the same edge as count_out.
    always_comb begin
        bcd_tens_d = 4'(int'(count_d) / 10);
        bcd_ones_d = 4'(int'(count_d) % 10);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bcd_tens_q <= BCD_TENS_INIT;
            bcd_ones_q <= BCD_ONES_INIT;
        end else begin
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
        end
    end

    assign bcd_tens_out = bcd_tens_q;
    assign bcd_ones_out = bcd_ones_q;
`endif

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench for turn_timer: an up-counting and a down-counting instance
// share controls and are checked every cycle against an elapsed-time model.
module tb_turn_timer;

    localparam int CLK_HZ = 4;
    localparam int T      = 3;
    localparam int PERIOD = CLK_HZ * T;

    logic clk = 1'b0;
    logic rst = 1'b1, clr = 1'b0, start = 1'b0, pause = 1'b0;
    logic ar0 = 1'b0, ar1 = 1'b1;

    logic       done0, exp0, run0, done1, exp1, run1;
    logic [1:0] cnt0, cnt1;

    int n_chk  = 0;
    int n_pass = 0;
    int e      = 0;

    always #5 clk = ~clk;

`ifdef TURN_TIMER_BCD_EN
    logic [3:0] bt0, bo0, bt1, bo1, bt2, bo2;
    logic       done2, exp2, run2;
    logic [3:0] cnt2;
`endif

    turn_timer #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(T), .COUNT_DOWN(0)) u_up (
        .clk_in(clk), .rst_in(rst), .start_in(start), .pause_in(pause),
        .clear_in(clr), .auto_reload_in(ar0),
        .done(done0), .expired_out(exp0), .running_out(run0), .count_out(cnt0)
`ifdef TURN_TIMER_BCD_EN
        , .bcd_tens_out(bt0), .bcd_ones_out(bo0)
`endif
    );

    turn_timer #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(T), .COUNT_DOWN(1)) u_dn (
        .clk_in(clk), .rst_in(rst), .start_in(start), .pause_in(pause),
        .clear_in(clr), .auto_reload_in(ar1),
        .done(done1), .expired_out(exp1), .running_out(run1), .count_out(cnt1)
`ifdef TURN_TIMER_BCD_EN
        , .bcd_tens_out(bt1), .bcd_ones_out(bo1)
`endif
    );

`ifdef TURN_TIMER_BCD_EN
    turn_timer #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(12), .COUNT_DOWN(1)) u_bcd (
        .clk_in(clk), .rst_in(rst), .start_in(start), .pause_in(pause),
        .clear_in(clr), .auto_reload_in(1'b0),
        .done(done2), .expired_out(exp2), .running_out(run2), .count_out(cnt2),
        .bcd_tens_out(bt2), .bcd_ones_out(bo2)
    );
`endif

    // Model: mode 0 idle, 1 running (possibly paused), 2 expired; el = active cycles into the period.
    int m_mode[2]   = '{0, 0};
    int m_el[2]     = '{0, 0};
    bit m_paused[2] = '{0, 0};
    bit m_done[2]   = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (rst || clr) begin
                m_mode[i] = 0; m_el[i] = 0; m_paused[i] = 1'b0;
            end else if (start) begin
                m_mode[i] = 1; m_el[i] = 0; m_paused[i] = 1'b0;
            end else if (m_mode[i] == 1) begin
                m_paused[i] = pause;
                if (!pause) begin
                    m_el[i]++;
                    if (m_el[i] == PERIOD) begin
                        m_el[i]   = 0;
                        m_done[i] = 1'b1;
                        if (!((i == 0) ? ar0 : ar1)) m_mode[i] = 2;
                    end
                end
            end
        end
    end

    function automatic int exp_cnt(input int i);
        int sec = m_el[i] / CLK_HZ;
        return (i == 1) ? T - sec : sec;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    endtask

    always @(negedge clk) begin
        chk("up.count",   int'(cnt0), exp_cnt(0));
        chk("up.done",    int'(done0), int'(m_done[0]));
        chk("up.running", int'(run0), int'(m_mode[0] == 1 && !m_paused[0]));
        chk("up.expired", int'(exp0), int'(m_mode[0] == 2));
        chk("dn.count",   int'(cnt1), exp_cnt(1));
        chk("dn.done",    int'(done1), int'(m_done[1]));
        chk("dn.running", int'(run1), int'(m_mode[1] == 1 && !m_paused[1]));
        chk("dn.expired", int'(exp1), int'(m_mode[1] == 2));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_e(input int n);
        step(n - e);
        e = n;
    endtask

    task automatic start_e0();
        start = 1'b1;
        step(1);
        start = 1'b0;
        e = 0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst.up_count", int'(cnt0), 0);
        chk("rst.dn_count", int'(cnt1), 3);
        chk("rst.running",  int'(run0), 0);
        chk("rst.done",     int'(done0), 0);

        // Up stops at expiry; down auto-reloads.
        start_e0();
        chk("t1.up_e0", int'(cnt0), 0);
        chk("t1.run_e0", int'(run0), 1);
        chk("t1.dn_e0", int'(cnt1), 3);
`ifdef TURN_TIMER_BCD_EN
        chk("bcd.tens_e0", int'(bt2), 1);
        chk("bcd.ones_e0", int'(bo2), 2);
`endif
        to_e(4);  chk("t1.up_e4", int'(cnt0), 1); chk("t1.dn_e4", int'(cnt1), 2);
        to_e(8);  chk("t1.up_e8", int'(cnt0), 2);
        to_e(11); chk("t1.up_done_e11", int'(done0), 0);
        to_e(12);
        chk("t1.up_done_e12", int'(done0), 1);
        chk("t1.up_exp_e12", int'(exp0), 1);
        chk("t1.up_cnt_e12", int'(cnt0), 0);
        chk("t1.dn_done_e12", int'(done1), 1);
        chk("t1.dn_cnt_e12", int'(cnt1), 3);
`ifdef TURN_TIMER_BCD_EN
        chk("bcd.tens_e12", int'(bt2), 0);
        chk("bcd.ones_e12", int'(bo2), 9);
`endif
        to_e(13); chk("t1.up_done_e13", int'(done0), 0);
        to_e(24); chk("t1.dn_done_e24", int'(done1), 1); chk("t1.dn_exp_e24", int'(exp1), 0);
        to_e(26);

        // Five paused cycles push expiry from E12 to E17.
        start_e0();
        to_e(2); pause = 1'b1;
        to_e(7); pause = 1'b0;
        chk("t2.frozen_e7", int'(cnt0), 0);
        to_e(9);  chk("t2.tick_e9", int'(cnt0), 1);
        to_e(16); chk("t2.done_e16", int'(done0), 0);
        to_e(17); chk("t2.done_e17", int'(done0), 1);
        to_e(19);

        // Clear in the expiry cycle wins.
        start_e0();
        to_e(11); clr = 1'b1;
        to_e(12); clr = 1'b0;
        chk("t3.done", int'(done0), 0);
        chk("t3.exp",  int'(exp0), 0);
        chk("t3.cnt",  int'(cnt0), 0);
        to_e(14);

        // Reset mid-run, restart at E10, expiry after E22.
        start_e0();
        to_e(5); rst = 1'b1;
        to_e(6); rst = 1'b0;
        chk("t4.rst_run", int'(run0), 0);
        chk("t4.rst_dn",  int'(cnt1), 3);
        to_e(9);  start = 1'b1;
        to_e(10); start = 1'b0;
        to_e(21); chk("t4.done_e21", int'(done0), 0);
        to_e(22); chk("t4.done_e22", int'(done0), 1);
        to_e(24);

        // Start held across a tick keeps reloading; expiry 12 cycles after release.
        start_e0();
        to_e(3); start = 1'b1;
        to_e(6); start = 1'b0;
        chk("t5.reload", int'(cnt0), 0);
        to_e(17); chk("t5.done_e17", int'(done0), 0);
        to_e(18); chk("t5.done_e18", int'(done0), 1);

        // Pause ignored in EXPIRED and IDLE.
        pause = 1'b1; step(3);
        chk("t6.exp_hold", int'(exp0), 1);
        clr = 1'b1; step(1); clr = 1'b0;
        step(3); pause = 1'b0;
        chk("t6.idle_run", int'(run0), 0);

        // Up mode auto-reload with a pause straddling a period boundary.
        ar0 = 1'b1;
        start_e0();
        to_e(10); pause = 1'b1;
        to_e(13); pause = 1'b0;
        to_e(15); chk("t7.done_e15", int'(done0), 1);
        to_e(27); chk("t7.done_e27", int'(done0), 1); chk("t7.exp", int'(exp0), 0);
        ar0 = 1'b0;
        to_e(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/turn_timer.md
# turn_timer

Parametrised second-resolution game timer that generalises the fixed 10 s / 50 MHz counter. It divides `clk_in` down to 1 Hz and counts a configurable number of seconds, either up or down. It supports start, pause, clear and auto-reload, and reports expiry both as a one-cycle pulse and as a held flag. It sits between the game-control FSM (turn limits) and the VGA overlay, which displays `count_out`.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency; prescaler terminal count is `CLK_HZ-1`.
- `TIMEOUT_S`, 10, seconds per period; legal range 1..(2^CNT_W - 1).
- `COUNT_DOWN`, 0, 0: `count_out` runs 0..TIMEOUT_S-1; 1: runs TIMEOUT_S..1.
- `CNT_W`, `$clog2(TIMEOUT_S+1)`, width of `count_out`.
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `start_in` in 1: level sampled each cycle; loads and runs.
- `pause_in` in 1: level; freezes the timer while high in RUN.
- `clear_in` in 1: returns to IDLE and reloads.
- `auto_reload_in` in 1: level; if high at expiry, the timer restarts instead of stopping.
- `done` out 1: one-cycle expiry pulse.
- `expired_out` out 1: held high in EXPIRED.
- `running_out` out 1: high in RUN.
- `count_out` out CNT_W: current seconds value.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Reset values: IDLE, prescaler 0, `done`=0, `expired_out`=0, `running_out`=0, `count_out` = 0 (up) or TIMEOUT_S (down).
- Input priority: `rst_in` > `clear_in` > `start_in` > `pause_in`.
- `clear_in`, any state:
  - go to IDLE;
  - prescaler=0;
  - `count_out` = initial value;
  - `done` forced 0.
- `start_in`, any state:
  - go to RUN;
  - prescaler=0;
  - `count_out` = initial value.
- `start_in` held high keeps reloading, so the timer advances only once `start_in` drops.
- RUN with `pause_in`=1: go to PAUSE. Prescaler and count hold.
- PAUSE with `pause_in`=0: go to RUN. The prescaler resumes from its held value.
- `pause_in` is ignored in IDLE and EXPIRED.
- Tick: in RUN with `pause_in`=0 and prescaler==CLK_HZ-1.
  - The prescaler wraps to 0.
  - Up mode: `count_out`+1.
  - Down mode: `count_out`-1.
- Expiry is the tick that occurs while `count_out` is at its last value (TIMEOUT_S-1 up, 1 down):
  - `count_out` reloads to its initial value;
  - `done`=1 for one cycle;
  - `auto_reload_in`=1: stay in RUN;
  - otherwise: go to EXPIRED, `expired_out`=1.
- EXPIRED: holds until `start_in` or `clear_in`.
- Arithmetic: the prescaler is `$clog2(CLK_HZ)` bits. `count_out` never leaves its legal range (no wrap past the bounds).

## Timing
- All outputs are registered.
- `start_in` is sampled at edge E0. `running_out`=1 and `count_out` is initial after E0.
- The n-th tick updates `count_out` at edge E(n·CLK_HZ).
- `done` is high for the cycle after edge E(TIMEOUT_S·CLK_HZ), with zero pauses.
- Each paused cycle delays all later events by exactly one cycle.
- `start_in` coincident with a tick: start wins; reload, no `done`.
- `clear_in` coincident with expiry: clear wins; no `done`, no EXPIRED.
- `rst_in` mid-run: all reset values at the next edge; no `done`.
- Auto-reload: the period is seamless. The next `done` comes exactly TIMEOUT_S·CLK_HZ cycles later.

## Configuration
- Macro `TURN_TIMER_BCD_EN`.
- Defined:
  - adds outputs `bcd_tens_out` [3:0] and `bcd_ones_out` [3:0], registered and updated in the same cycle as `count_out`;
  - reset to the BCD of the reset `count_out`;
  - requires TIMEOUT_S ≤ 99; elaboration error otherwise.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

## Structure
- Package `timer_pkg`:
  - `timer_state_t` enum (IDLE, RUN, PAUSE, EXPIRED);
  - function `cnt_init(COUNT_DOWN, TIMEOUT_S)`.
- Sub-module `tick_prescaler`:
  - parameter CLK_HZ;
  - inputs `clk_in`, `rst_in`, `clr`, `en`;
  - output `tick`, combinational: asserted when `en` is high and count==CLK_HZ-1.
- `turn_timer` holds the FSM, the seconds counter and the optional BCD logic.

## Test plan
Benches use CLK_HZ=4 and TIMEOUT_S=3 unless stated.
- Up mode, start pulse at E0 -> `count_out` 0,1,2 at E0,E4,E8; `done` high only after E12; `expired_out`=1, `count_out`=0.
- COUNT_DOWN=1, `auto_reload_in`=1 -> `count_out` 3,2,1,3,2,…; `done` after E12 and E24; `expired_out` stays 0.
- Pause high for 5 cycles starting after E2 -> `done` moves to after E17; `count_out` frozen during pause.
- `clear_in` asserted in the expiry cycle (the cycle before E12) -> no `done`; IDLE; `count_out`=0.
- `rst_in` pulse at E6 mid-run, then `start_in` at E10 -> all outputs at reset values after E6; `done` after E22.
- With `TURN_TIMER_BCD_EN`, TIMEOUT_S=12, COUNT_DOWN=1 -> after start, tens=1 ones=2; after 3 ticks, tens=0 ones=9.
